// File: rtl/store_sequencer.sv
// Read-modify-write store sequencer: full-word stores write directly, byte and
// halfword stores first read the target word, then merge the new low bits in.
module store_sequencer #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] B,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] b_q;
  logic [1:0]  type_q;
  logic [31:0] mdr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      b_q     <= '0;
      type_q  <= '0;
      mdr_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q  <= addr;
            b_q     <= B;
            type_q  <= store_type;
            cnt_q   <= LAT_INIT;
            state_q <= store_type[1] ? S_READ : S_WRITE;
          end
        end
        S_READ: begin
          // Counter runs LAT_INIT..0, so the read phase spans MEM_LAT+1 cycles
          // and the final one sees the data for the address presented first.
          if (cnt_q == 3'd0) begin
            mdr_q   <= mem_rdata;
            state_q <= S_WRITE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_WRITE: state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Moore decode: outputs depend only on the state and the latched registers.
  always_comb begin
    mem_addr  = '0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      S_IDLE: busy = 1'b0;
      S_READ: mem_addr = addr_q;
      S_WRITE: begin
        mem_wr   = 1'b1;
        mem_addr = addr_q;
        if (!type_q[1]) begin
          mem_wdata = b_q;
        end else if (type_q[0]) begin
          mem_wdata = {mdr_q[31:16], b_q[15:0]};
        end else begin
          mem_wdata = {mdr_q[31:8], b_q[7:0]};
        end
      end
      S_DONE:  done = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_store_sequencer.sv
// Scoreboard bench for store_sequencer: two instances (MEM_LAT=1 and 3) fed by
// a latency-accurate memory model; expected writes/dones are queued at issue time.
module tb_store_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start_s [2];
  logic [1:0]  type_s  [2];
  logic [31:0] addr_s  [2];
  logic [31:0] b_s     [2];
  logic [31:0] rdata_s [2];
  logic [31:0] maddr_s [2];
  logic [31:0] wdata_s [2];
  logic        wr_s    [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic [2:0]  state_s [2];

  int lat_of [2] = '{1, 3};

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a == 32'h100) ? 32'hAABBCCDD : 32'hDEADBEEF;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 3;
    logic [31:0] pipe [3];

    // Memory returns data for an address exactly LAT cycles after it is presented.
    always @(posedge clk) begin
      pipe[0] <= memval(maddr_s[gi]);
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign rdata_s[gi] = pipe[LAT-1];

    store_sequencer #(.MEM_LAT(LAT)) u_dut (
      .clk        (clk),
      .reset      (reset_n),
      .start      (start_s[gi]),
      .store_type (type_s[gi]),
      .addr       (addr_s[gi]),
      .B          (b_s[gi]),
      .mem_rdata  (rdata_s[gi]),
      .mem_addr   (maddr_s[gi]),
      .mem_wr     (wr_s[gi]),
      .mem_wdata  (wdata_s[gi]),
      .busy       (busy_s[gi]),
      .done       (done_s[gi]),
      .state      (state_s[gi])
    );
  end

  typedef struct { int dut; logic [31:0] addr; logic [31:0] data; int cyc; } wexp_t;
  typedef struct { int dut; int cyc; } dexp_t;
  wexp_t wq[$];
  dexp_t dq[$];

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    wexp_t we;
    dexp_t de;
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        if (wr_s[k] === 1'b1) begin
          if (wq.size() == 0) begin
            chk($sformatf("unexpected_write_dut%0d", k), wdata_s[k], 32'hxxxxxxxx);
          end else begin
            we = wq.pop_front();
            chk("wr_dut", 32'(k), 32'(we.dut));
            chk("wr_addr", maddr_s[k], we.addr);
            chk("wr_data", wdata_s[k], we.data);
            chk("wr_cycle", 32'(cyc), 32'(we.cyc));
            $display("write dut%0d addr=%08h data=%08h cycle=%0d", k, maddr_s[k], wdata_s[k], cyc);
          end
        end
        if (done_s[k] === 1'b1) begin
          if (dq.size() == 0) begin
            chk($sformatf("unexpected_done_dut%0d", k), 32'(cyc), 32'hxxxxxxxx);
          end else begin
            de = dq.pop_front();
            chk("done_dut", 32'(k), 32'(de.dut));
            chk("done_cycle", 32'(cyc), 32'(de.cyc));
            chk("done_busy", {31'b0, busy_s[k]}, 32'd1);
          end
        end
        if (busy_s[k] !== 1'b1) begin
          chk("idle_addr", maddr_s[k], 32'h0);
          chk("idle_wdata", wdata_s[k], 32'h0);
          chk("idle_flags", {30'b0, wr_s[k], done_s[k]}, 32'h0);
          chk("idle_state", {29'b0, state_s[k]}, 32'h0);
        end
        if (state_s[k] === 3'd1) begin
          chk("read_flags_wdata", wdata_s[k] | {31'b0, wr_s[k]}, 32'h0);
        end
      end
    end
  end

  task automatic wait_idle(input int k);
    int i;
    for (i = 0; i < 60 && busy_s[k] !== 1'b0; i++) @(negedge clk);
    if (busy_s[k] !== 1'b0) chk("idle_timeout", {31'b0, busy_s[k]}, 32'h0);
  endtask

  // Issue one store on instance k; caller is at a negedge.
  task automatic issue(input int k, input logic [1:0] t, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_data);
    int cur;
    int wcyc;
    wait_idle(k);
    cur = cyc;
    start_s[k] = 1'b1;
    type_s[k]  = t;
    addr_s[k]  = a;
    b_s[k]     = b;
    wcyc = cur + 1 + (t[1] ? lat_of[k] + 1 : 0);
    wq.push_back('{k, a, exp_data, wcyc});
    dq.push_back('{k, wcyc + 1});
    $display("issue dut%0d type=%b addr=%08h B=%08h expect %08h at cycle %0d", k, t, a, b, exp_data, wcyc);
    @(negedge clk);
    start_s[k] = 1'b0;
    type_s[k]  = ~t;
    addr_s[k]  = 32'hFFFF_FFF0;
    b_s[k]     = 32'h0;
  endtask

  initial begin
    int cur;
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 1'b0;
      type_s[k]  = 2'b00;
      addr_s[k]  = 32'h0;
      b_s[k]     = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_state", {29'b0, state_s[k]}, 32'h0);
      chk("reset_flags", {29'b0, wr_s[k], busy_s[k], done_s[k]}, 32'h0);
      chk("reset_addr", maddr_s[k], 32'h0);
      chk("reset_wdata", wdata_s[k], 32'h0);
    end
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(negedge clk);

    issue(0, 2'b00, 32'h40,  32'h11223344, 32'h11223344);
    issue(0, 2'b10, 32'h100, 32'h12345678, 32'hAABBCC78);
    issue(0, 2'b11, 32'h100, 32'h12345678, 32'hAABB5678);
    issue(1, 2'b11, 32'h100, 32'h12345678, 32'hAABB5678);
    issue(1, 2'b10, 32'h100, 32'h12345678, 32'hAABBCC78);
    issue(1, 2'b00, 32'h80,  32'hCAFEF00D, 32'hCAFEF00D);

    // start held high; inputs change while busy, second request waits one IDLE cycle
    wait_idle(0);
    cur = cyc;
    start_s[0] = 1'b1; type_s[0] = 2'b00; addr_s[0] = 32'h40; b_s[0] = 32'h55667788;
    wq.push_back('{0, 32'h40, 32'h55667788, cur + 1});
    dq.push_back('{0, cur + 2});
    wq.push_back('{0, 32'h100, 32'hAABB5678, cur + 6});
    dq.push_back('{0, cur + 7});
    $display("issue dut0 held start: word then halfword");
    @(negedge clk);
    type_s[0] = 2'b11; addr_s[0] = 32'h100; b_s[0] = 32'h12345678;
    repeat (3) @(negedge clk);
    start_s[0] = 1'b0; type_s[0] = 2'b00; addr_s[0] = 32'hFFFF_FFF0; b_s[0] = 32'h0;

    // reset during the second READ cycle of a byte store aborts it
    wait_idle(0);
    $display("issue dut0 byte store aborted by reset");
    start_s[0] = 1'b1; type_s[0] = 2'b10; addr_s[0] = 32'h100; b_s[0] = 32'h12345678;
    @(negedge clk);
    start_s[0] = 1'b0;
    chk("abort_in_read", {29'b0, state_s[0]}, 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_state", {29'b0, state_s[0]}, 32'h0);
    chk("abort_flags", {30'b0, wr_s[0], done_s[0]}, 32'h0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    issue(0, 2'b00, 32'h44, 32'h0BADF00D, 32'h0BADF00D);

    wait_idle(0);
    for (int i = 0; i < 10; i++) begin
      chk("quiet_busy", {31'b0, busy_s[0]}, 32'h0);
      @(negedge clk);
    end

    for (int i = 0; i < 100 && (wq.size() != 0 || dq.size() != 0); i++) @(negedge clk);
    chk("pending_writes", 32'(wq.size()), 32'h0);
    chk("pending_dones", 32'(dq.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
